// File: rtl/led_pwm_pkg.sv
// +----------------------------------------------------------------------+
// | led_pwm_pkg: shared constants for the LED PWM output stage           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package led_pwm_pkg;

    localparam int LED_PWM_W = 8;

    typedef logic [LED_PWM_W-1:0] pwm_t;

    localparam logic [1:0] LED_REG_MASK  = 2'd0;
    localparam logic [1:0] LED_REG_DUTY  = 2'd1;
    localparam logic [1:0] LED_REG_BLINK = 2'd2;

    localparam pwm_t LED_PWM_MAX   = '1;
    localparam pwm_t LED_RST_MASK  = '0;
    localparam pwm_t LED_RST_BLINK = '0;

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// +----------------------------------------------------------------------+
// | led_tick_gen: prescaler producing one PWM tick every PRESCALE_DIV clk |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module led_tick_gen #(
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned c_cnt_w = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PRESCALE_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // With a divide of 1 the counter sits at 0 == c_last, so tick is constant.
    assign tick_o = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (tick_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pwm_driver.sv
// +----------------------------------------------------------------------+
// | led_pwm_driver: masked, frame-synchronous 8-bit PWM LED output stage |
// | Optional blink feature: LED_PWM_BLINK_EN       Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 4,
    parameter logic [7:0]  DEFAULT_DUTY = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] led_o,
    output logic       frame_o
);

    logic w_tick;
    logic w_commit;
    logic w_wr_mask;
    logic w_wr_duty;
    logic w_blink_on;

    pwm_t r_pwm_cnt;
    pwm_t r_mask_shd;
    pwm_t r_mask_act;
    pwm_t r_duty_shd;
    pwm_t r_duty_act;
    logic [7:0] r_led;
    logic       r_frame;

    led_tick_gen #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_o (w_tick)
    );

    assign w_commit  = w_tick & (r_pwm_cnt == LED_PWM_MAX);
    assign w_wr_mask = wr_en & (wr_addr == LED_REG_MASK);
    assign w_wr_duty = wr_en & (wr_addr == LED_REG_DUTY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt  <= '0;
            r_mask_shd <= LED_RST_MASK;
            r_mask_act <= LED_RST_MASK;
            r_duty_shd <= DEFAULT_DUTY;
            r_duty_act <= DEFAULT_DUTY;
            r_led      <= '0;
            r_frame    <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + pwm_t'(1);
            end
            if (w_wr_mask) begin
                r_mask_shd <= wr_data;
            end
            if (w_wr_duty) begin
                r_duty_shd <= wr_data;
            end
            // A write landing on the commit cycle skips the shadow stage.
            if (w_commit) begin
                r_mask_act <= w_wr_mask ? wr_data : r_mask_shd;
                r_duty_act <= w_wr_duty ? wr_data : r_duty_shd;
            end
            r_frame <= w_commit;
            r_led   <= r_mask_act & {8{r_pwm_cnt < r_duty_act}} & {8{w_blink_on}};
        end
    end

`ifdef LED_PWM_BLINK_EN
    logic w_wr_blink;
    pwm_t r_blink_shd;
    pwm_t r_blink_act;
    pwm_t r_frame_cnt;
    logic r_blink_on;

    assign w_wr_blink = wr_en & (wr_addr == LED_REG_BLINK);
    assign w_blink_on = r_blink_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_shd <= LED_RST_BLINK;
            r_blink_act <= LED_RST_BLINK;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            if (w_wr_blink) begin
                r_blink_shd <= wr_data;
            end
            if (w_commit) begin
                r_blink_act <= w_wr_blink ? wr_data : r_blink_shd;
            end
            // A zero period parks the blinker in the on phase.
            if (r_blink_act == '0) begin
                r_frame_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (w_commit) begin
                if (r_frame_cnt == r_blink_act - pwm_t'(1)) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + pwm_t'(1);
                end
            end
        end
    end
`else
    assign w_blink_on = 1'b1;
`endif

    assign led_o   = r_led;
    assign frame_o = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
// +----------------------------------------------------------------------+
// | tb_led_pwm_driver: directed self-checking bench for led_pwm_driver   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_led_pwm_driver;
    import led_pwm_pkg::*;

`ifdef LED_PWM_BLINK_EN
    localparam bit c_blink_built = 1'b1;
`else
    localparam bit c_blink_built = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] led_o;
    logic       frame_o;
    logic [7:0] led2_o;
    logic       frame2_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .PRESCALE_DIV (1),
        .DEFAULT_DUTY (8'hFF)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .led_o   (led_o),
        .frame_o (frame_o)
    );

    led_pwm_driver #(
        .PRESCALE_DIV (3),
        .DEFAULT_DUTY (8'hFF)
    ) u_dut_div3 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .led_o   (led2_o),
        .frame_o (frame2_o)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at the negedge of a frame_o cycle (pwm_cnt == 0); returns at the next one.
    task automatic run_frame(input string tag, input logic [7:0] mask, input logic [7:0] duty,
                             input bit blink, input int wr_k, input logic [1:0] addr,
                             input logic [7:0] data);
        int mism = 0;
        int on   = 0;
        logic [7:0] exp;
        for (int k = 0; k < 256; k++) begin
            if (k == wr_k) begin
                wr_en   = 1'b1;
                wr_addr = addr;
                wr_data = data;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            exp = (blink && (k < int'(duty))) ? mask : 8'h00;
            if (led_o !== exp) mism++;
            if (k < 255 && frame_o !== 1'b0) mism++;
            if (led_o != 8'h00) on++;
        end
        wr_en = 1'b0;
        check_eq({tag, "_pattern"}, mism, 0);
        check_eq({tag, "_on_cycles"}, on, (blink && mask != 8'h00) ? int'(duty) : 0);
        check_eq({tag, "_frame"}, int'(frame_o), 1);
    endtask

    task automatic count_to_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_o && n < 300);
    endtask

    task automatic wait_frame();
        int n;
        count_to_frame(n);
        check_eq("wait_frame", int'(frame_o), 1);
    endtask

    initial begin : main
        int n;
        int on2;
        int bad2;
        int early2;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_led", int'(led_o), 0);
        check_eq("rst_frame", int'(frame_o), 0);
        count_to_frame(n);
        check_eq("rst_first_frame_dist", n, 256);

        // Mask 0 after reset; mask and duty enter through the shadows.
        run_frame("f_rst", 8'h00, 8'hFF, 1'b1, 10, LED_REG_MASK, 8'hA5);
        run_frame("f_duty_ff", 8'hA5, 8'hFF, 1'b1, 20, LED_REG_DUTY, 8'h40);
        run_frame("f_duty40_a", 8'hA5, 8'h40, 1'b1, -1, LED_REG_MASK, 8'h00);
        run_frame("f_duty40_b", 8'hA5, 8'h40, 1'b1, -1, LED_REG_MASK, 8'h00);

        // Divide-by-3 instance: frame of 768 clocks, 64 ticks lit.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame2_o && n < 1000);
        check_eq("d3_sync", int'(frame2_o), 1);
        on2 = 0; bad2 = 0; early2 = 0;
        for (int j = 1; j <= 768; j++) begin
            @(negedge clk);
            if (led2_o != 8'h00) on2++;
            if (led2_o != 8'h00 && led2_o != 8'hA5) bad2++;
            if (j < 768 && frame2_o) early2++;
        end
        check_eq("d3_on_cycles", on2, 192);
        check_eq("d3_led_value", bad2, 0);
        check_eq("d3_early_frame", early2, 0);
        check_eq("d3_frame_period", int'(frame2_o), 1);

        wait_frame();
        run_frame("f_mid_wr_old", 8'hA5, 8'h40, 1'b1, 100, LED_REG_DUTY, 8'h10);
        run_frame("f_mid_wr_new", 8'hA5, 8'h10, 1'b1, 255, LED_REG_MASK, 8'h0F);
        run_frame("f_bypass", 8'h0F, 8'h10, 1'b1, 50, LED_REG_DUTY, 8'h00);
        run_frame("f_duty0", 8'h0F, 8'h00, 1'b1, 10, LED_REG_DUTY, 8'hFF);
        run_frame("f_duty255", 8'h0F, 8'hFF, 1'b1, 5, LED_REG_MASK, 8'hFF);
        run_frame("f_blink_wr", 8'hFF, 8'hFF, 1'b1, 5, LED_REG_BLINK, 8'h03);
        run_frame("f_blink_on1", 8'hFF, 8'hFF, 1'b1, -1, LED_REG_MASK, 8'h00);
        run_frame("f_blink_on2", 8'hFF, 8'hFF, 1'b1, -1, LED_REG_MASK, 8'h00);
        run_frame("f_blink_on3", 8'hFF, 8'hFF, 1'b1, -1, LED_REG_MASK, 8'h00);
        run_frame("f_blink_off1", 8'hFF, 8'hFF, !c_blink_built, -1, LED_REG_MASK, 8'h00);
        run_frame("f_blink_off2", 8'hFF, 8'hFF, !c_blink_built, -1, LED_REG_MASK, 8'h00);
        run_frame("f_blink_off3", 8'hFF, 8'hFF, !c_blink_built, -1, LED_REG_MASK, 8'h00);
        run_frame("f_blink_on4", 8'hFF, 8'hFF, 1'b1, 5, LED_REG_BLINK, 8'h00);
        run_frame("f_blink_zero", 8'hFF, 8'hFF, 1'b1, 5, 2'd3, 8'h00);
        run_frame("f_addr3", 8'hFF, 8'hFF, 1'b1, -1, LED_REG_MASK, 8'h00);

        // Mid-frame reset discards a pending shadow write.
        repeat (100) @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = LED_REG_MASK;
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("pre_rst_led", int'(led_o), 8'hFF);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_led", int'(led_o), 0);
        check_eq("mid_rst_frame", int'(frame_o), 0);
        count_to_frame(n);
        check_eq("mid_rst_frame_dist", n, 256);
        run_frame("f_post_rst", 8'h00, 8'hFF, 1'b1, -1, LED_REG_MASK, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
